// File: rtl/dmem_reader_if.sv
// Bus bundle for dmem_reader: command inputs, memory read port and output byte stream.
// master = the reader itself; slave = the command source, memory and sink around it.
interface dmem_reader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, base_addr, count, mem_data, out_ready,
    output mem_addr, out_data, out_valid, busy, done
  );

  modport slave (
    output start, base_addr, count, mem_data, out_ready,
    input  mem_addr, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/dmem_reader.sv
// Sweeps count addresses of a 1-cycle-latency memory and streams the bytes out through a 2-entry FIFO.
// Define DMEM_READER_CSUM_EN to add the csum output (running byte sum of the current command).
module dmem_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  dmem_reader_if.master       bus
`ifdef DMEM_READER_CSUM_EN
  ,
  output logic [DATA_W-1:0]   csum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  state_t            state_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W:0]   issue_left_q;
  logic [ADDR_W:0]   deliver_left_q;
  logic              pend_q;
  logic [DATA_W-1:0] fifo_q [2];
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        occ_q;
  logic              busy_q;
  logic              done_q;

  logic              pop;
  logic              issue;
  logic [2:0]        inflight;

  // mem_addr_q always holds the next address to read; a cycle "issues" it only when
  // the FIFO plus the read already in flight leave room after this cycle's pop.
  assign pop      = (occ_q != 2'd0) && bus.out_ready;
  assign inflight = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
  assign issue    = (state_q == S_FETCH) && (inflight < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      mem_addr_q     <= '0;
      issue_left_q   <= '0;
      deliver_left_q <= '0;
      pend_q         <= 1'b0;
      fifo_q[0]      <= '0;
      fifo_q[1]      <= '0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      occ_q          <= 2'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      pend_q <= issue;

      if (pend_q) begin
        fifo_q[wr_ptr_q] <= bus.mem_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q       <= ~rd_ptr_q;
        deliver_left_q <= deliver_left_q - CNT_ONE;
      end
      case ({pend_q, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase

      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.count == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q        <= S_FETCH;
              busy_q         <= 1'b1;
              mem_addr_q     <= bus.base_addr;
              issue_left_q   <= bus.count;
              deliver_left_q <= bus.count;
            end
          end
        end
        S_FETCH: begin
          if (issue) begin
            issue_left_q <= issue_left_q - CNT_ONE;
            // Leave the last issued address on the bus rather than stepping past it.
            if (issue_left_q == CNT_ONE) begin
              state_q <= S_DRAIN;
            end else begin
              mem_addr_q <= mem_addr_q + ADDR_ONE;
            end
          end
        end
        S_DRAIN: begin
          if (pop && (deliver_left_q == CNT_ONE)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.out_data  = fifo_q[rd_ptr_q];
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifdef DMEM_READER_CSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if ((state_q == S_IDLE) && bus.start) begin
      csum_q <= '0;
    end else if (pop) begin
      csum_q <= csum_q + bus.out_data;
    end
  end

  assign csum = csum_q;
`endif

endmodule

// File: tb/tb_dmem_reader.sv
// Self-checking bench for dmem_reader: memory model mem[i] = A0 + i, expected bytes from a sweep model.
// Exercises csum as well when DMEM_READER_CSUM_EN is defined.
module tb_dmem_reader;

  typedef logic [7:0] byte_q_t [$];

  logic clk;
  logic rst_n;
  logic [7:0] mem [16];

  dmem_reader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

`ifdef DMEM_READER_CSUM_EN
  logic [7:0] csum;
  logic [7:0] csum_done;
`endif

  dmem_reader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DMEM_READER_CSUM_EN
    ,
    .csum  (csum)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // observations gathered by run_cmd
  byte_q_t    got_q;
  logic [3:0] addr_trace [$];
  int first_valid_cyc, done_cyc, busy_first, busy_last;
  logic busy_at_done;
  int stab_viol, ahead_viol;
  bit timeout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'hA0 + i);
  end

  always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic byte_q_t model_bytes(input int b, input int c);
    byte_q_t q;
    for (int i = 0; i < c; i++) q.push_back(8'(8'hA0 + ((b + i) % 16)));
    return q;
  endfunction

  function automatic logic [7:0] model_sum(input byte_q_t e);
    logic [7:0] s = 8'h00;
    foreach (e[i]) s = s + e[i];
    return s;
  endfunction

  function automatic int q_diff(input byte_q_t a, input byte_q_t e);
    int d = (a.size() > e.size()) ? a.size() - e.size() : e.size() - a.size();
    for (int i = 0; i < a.size() && i < e.size(); i++)
      if (a[i] !== e[i]) d++;
    return d;
  endfunction

  // Drives one command starting in the current cycle (cycle 0) and records what the DUT does.
  task automatic run_cmd(input logic [3:0] b, input logic [4:0] c, input int stall_lo,
                         input int stall_hi, input bit rnd_ready, input bit extra_start);
    int cyc = 0;
    int accepted = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [3:0] idx;
    bit finished = 0;
    got_q.delete();
    addr_trace.delete();
    first_valid_cyc = -1; done_cyc = -1; busy_first = -1; busy_last = -1;
    busy_at_done = 1'b0; stab_viol = 0; ahead_viol = 0; timeout = 0;
    bus.start = 1'b1; bus.base_addr = b; bus.count = c;
    bus.out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : !(cyc >= stall_lo && cyc <= stall_hi);
    while (!finished) begin
      @(negedge clk);
      if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) stab_viol++;
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.busy) begin
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
        idx = 4'(bus.mem_addr - b);
        if (int'(idx) > accepted + 2) ahead_viol++;
        if (addr_trace.size() == 0 || addr_trace[$] != bus.mem_addr) addr_trace.push_back(bus.mem_addr);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_data);
        accepted++;
      end
      if (bus.done) begin
        done_cyc = cyc;
        busy_at_done = bus.busy;
`ifdef DMEM_READER_CSUM_EN
        csum_done = csum;
`endif
        finished = 1;
      end else if (cyc >= 300) begin
        timeout = 1;
        finished = 1;
      end
      @(posedge clk); #1;
      cyc++;
      bus.start = extra_start && (cyc == 2);
      if (bus.start) begin
        bus.base_addr = 4'd9;
        bus.count = 5'd3;
      end
      bus.out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : !(cyc >= stall_lo && cyc <= stall_hi);
    end
    bus.start = 1'b0;
    $display("cmd base=%0d count=%0d bytes=%0d first_valid=%0d done_cyc=%0d busy=%0d..%0d",
             b, c, got_q.size(), first_valid_cyc, done_cyc, busy_first, busy_last);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.base_addr = '0; bus.count = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.mem_addr !== 4'd0) begin n_err++; $display("FAIL reset_mem_addr: got %0d need 0", bus.mem_addr); end
    n_cmp++; if (bus.out_data !== 8'd0) begin n_err++; $display("FAIL reset_out_data: got %h need 00", bus.out_data); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b need 0", bus.out_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b need 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b need 0", bus.done); end
`ifdef DMEM_READER_CSUM_EN
    n_cmp++; if (csum !== 8'd0) begin n_err++; $display("FAIL reset_csum: got %h need 00", csum); end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int d;
    run_cmd(4'd0, 5'd4, 1000, 1000, 1'b0, 1'b0);
    d = q_diff(got_q, model_bytes(0, 4));
    n_cmp++; if (d !== 0) begin n_err++; $display("FAIL basic_bytes: got %0d bytes %0d diffs, need A0..A3", got_q.size(), d); end
    n_cmp++; if (first_valid_cyc !== 3) begin n_err++; $display("FAIL basic_first_valid: got cycle %0d need 3", first_valid_cyc); end
    n_cmp++; if (done_cyc !== 7) begin n_err++; $display("FAIL basic_done: got cycle %0d need 7", done_cyc); end
    n_cmp++; if (busy_first !== 1 || busy_last !== 6) begin n_err++; $display("FAIL basic_busy: got cycles %0d..%0d need 1..6", busy_first, busy_last); end
    n_cmp++; if (busy_at_done !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done: got %b need 0", busy_at_done); end
  endtask

  task automatic test_wrap();
    int d;
    bit bad;
    run_cmd(4'd14, 5'd4, 1000, 1000, 1'b0, 1'b0);
    d = q_diff(got_q, model_bytes(14, 4));
    n_cmp++; if (d !== 0) begin n_err++; $display("FAIL wrap_bytes: got %0d bytes %0d diffs, need AE,AF,A0,A1", got_q.size(), d); end
    bad = (addr_trace.size() != 4);
    if (!bad) bad = (addr_trace[0] !== 4'd14) || (addr_trace[1] !== 4'd15) || (addr_trace[2] !== 4'd0) || (addr_trace[3] !== 4'd1);
    n_cmp++; if (bad) begin n_err++; $display("FAIL wrap_addr_seq: got %0d distinct addresses, need 14,15,0,1", addr_trace.size()); end
  endtask

  task automatic test_backpressure();
    int d;
    run_cmd(4'd0, 5'd8, 4, 7, 1'b0, 1'b0);
    d = q_diff(got_q, model_bytes(0, 8));
    n_cmp++; if (d !== 0) begin n_err++; $display("FAIL bp_bytes: got %0d bytes %0d diffs, need A0..A7", got_q.size(), d); end
    n_cmp++; if (stab_viol !== 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable stall cycles need 0", stab_viol); end
    n_cmp++; if (ahead_viol !== 0) begin n_err++; $display("FAIL bp_ahead: got %0d cycles >2 ahead need 0", ahead_viol); end
    n_cmp++; if (done_cyc !== 15) begin n_err++; $display("FAIL bp_done: got cycle %0d need 15", done_cyc); end
  endtask

  task automatic test_zero_and_ignore();
    int d;
    int late = 0;
    run_cmd(4'd0, 5'd0, 1000, 1000, 1'b0, 1'b0);
    n_cmp++; if (done_cyc !== 1) begin n_err++; $display("FAIL zero_done: got cycle %0d need 1", done_cyc); end
    n_cmp++; if (first_valid_cyc !== -1) begin n_err++; $display("FAIL zero_valid: got valid at cycle %0d need never", first_valid_cyc); end
    n_cmp++; if (busy_first !== -1) begin n_err++; $display("FAIL zero_busy: got busy at cycle %0d need never", busy_first); end
    run_cmd(4'd0, 5'd4, 1000, 1000, 1'b0, 1'b1);
    d = q_diff(got_q, model_bytes(0, 4));
    n_cmp++; if (d !== 0) begin n_err++; $display("FAIL ignore_bytes: got %0d bytes %0d diffs, need A0..A3", got_q.size(), d); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.busy || bus.out_valid) late++;
      @(posedge clk); #1;
    end
    n_cmp++; if (late !== 0) begin n_err++; $display("FAIL ignore_no_restart: got %0d active cycles need 0", late); end
  endtask

  task automatic test_async_reset();
    int acc = 0;
    int d;
    bus.start = 1'b1; bus.base_addr = 4'd0; bus.count = 5'd6; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 30 && acc < 2; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) acc++;
      if (acc < 2) begin @(posedge clk); #1; end
    end
    n_cmp++; if (acc !== 2) begin n_err++; $display("FAIL arst_setup: got %0d accepted need 2", acc); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mem_addr !== 4'd0)
      begin n_err++; $display("FAIL arst_immediate: got valid=%b busy=%b done=%b addr=%0d need all 0",
                              bus.out_valid, bus.busy, bus.done, bus.mem_addr); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_cmd(4'd3, 5'd2, 1000, 1000, 1'b0, 1'b0);
    d = q_diff(got_q, model_bytes(3, 2));
    n_cmp++; if (d !== 0) begin n_err++; $display("FAIL arst_bytes: got %0d bytes %0d diffs, need A3,A4", got_q.size(), d); end
    n_cmp++; if (first_valid_cyc !== 3) begin n_err++; $display("FAIL arst_first_valid: got cycle %0d need 3", first_valid_cyc); end
  endtask

  task automatic test_full_sweep();
    int d;
    run_cmd(4'd5, 5'd16, 1000, 1000, 1'b0, 1'b0);
    d = q_diff(got_q, model_bytes(5, 16));
    n_cmp++; if (d !== 0) begin n_err++; $display("FAIL full_bytes: got %0d bytes %0d diffs, need A5..AF,A0..A4", got_q.size(), d); end
    n_cmp++; if (done_cyc !== 19) begin n_err++; $display("FAIL full_done: got cycle %0d need 19", done_cyc); end
`ifdef DMEM_READER_CSUM_EN
    n_cmp++; if (csum_done !== 8'h78) begin n_err++; $display("FAIL full_csum: got %h need 78", csum_done); end
    n_cmp++; if (csum !== 8'h78) begin n_err++; $display("FAIL full_csum_hold: got %h need 78", csum); end
`endif
  endtask

  task automatic test_random();
    int d;
    int b, c;
    byte_q_t e;
    for (int t = 0; t < 12; t++) begin
      b = int'($urandom_range(0, 15));
      c = int'($urandom_range(0, 16));
      e = model_bytes(b, c);
      run_cmd(4'(b), 5'(c), 0, 0, 1'b1, 1'b0);
      d = q_diff(got_q, e);
      n_cmp++; if (d !== 0) begin n_err++; $display("FAIL rand_bytes[%0d]: got %0d bytes %0d diffs, need %0d bytes", t, got_q.size(), d, c); end
      n_cmp++; if (timeout || stab_viol !== 0 || ahead_viol !== 0)
        begin n_err++; $display("FAIL rand_stream[%0d]: got timeout=%0d unstable=%0d ahead=%0d need 0/0/0", t, timeout, stab_viol, ahead_viol); end
`ifdef DMEM_READER_CSUM_EN
      n_cmp++; if (csum_done !== model_sum(e)) begin n_err++; $display("FAIL rand_csum[%0d]: got %h need %h", t, csum_done, model_sum(e)); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_and_ignore();
    test_async_reset();
    test_full_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
